keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/keypad_row_sync.sv | 26 ++
 rtl/keypad_scanner.sv | 147 ++++++++++++++
 tb/tb_keypad_scanner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned NUM_KEYS = NUM_COLS * NUM_ROWS;
  localparam int unsigned POP_W    = $clog2(NUM_KEYS + 1);

  typedef enum logic {
    SCAN,
    EVAL
  } state_e;

  typedef logic [NUM_KEYS-1:0] keymap_t;

  function automatic logic [POP_W-1:0] popcount(input keymap_t v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  // Index of the lowest pressed key; only meaningful for a single-key map.
  function automatic logic [CODE_W-1:0] lowest_key(input keymap_t v);
    logic [CODE_W-1:0] code;
    logic              found;
    code  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (v[i] && !found) begin
        code  = CODE_W'(i);
        found = 1'b1;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Parameterized-width two-flop synchronizer; resets to all ones (idle rows).
module row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, per-scan snapshot, debounce
// by consecutive identical scans, and press/release event generation.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_release,
  output logic                key_down,
  output logic                key_multi
);

  localparam int unsigned DWELL_W = $clog2(SCAN_TICKS);
  localparam int unsigned MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned COL_W   = $clog2(NUM_COLS);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_TICKS - 1);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(DEBOUNCE_SCANS);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NUM_COLS - 1);

  state_e               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  keymap_t              snap_q, snap_d;
  keymap_t              prev_q, prev_d;
  keymap_t              acc_q, acc_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 valid_q, valid_d;
  logic                 release_q, release_d;
  logic [NUM_ROWS-1:0]  rows_sync;
  logic                 dwell_done;
  logic [POP_W-1:0]     acc_pop;

  row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (rows_sync)
  );

  assign dwell_done = (dwell_q == DWELL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (dwell_done && (col_q == COL_LAST)) state_d = EVAL;
      EVAL:    state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    col_n       = ~(NUM_COLS'(1) << col_q);
    acc_pop     = popcount(acc_q);
    key_down    = (acc_pop == POP_W'(1));
    key_multi   = (acc_pop >= POP_W'(2));
    key_code    = code_q;
    key_valid   = valid_q;
    key_release = release_q;
  end

  always_comb begin
    col_d     = col_q;
    dwell_d   = dwell_q;
    snap_d    = snap_q;
    prev_d    = prev_q;
    acc_d     = acc_q;
    match_d   = match_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_done) begin
          dwell_d = '0;
          for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            snap_d[r * NUM_COLS + int'(col_q)] = ~rows_sync[r];
          end
          if (col_q != COL_LAST) col_d = col_q + COL_W'(1);
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      EVAL: begin
        col_d = '0;
        if (snap_q == prev_q) begin
          if (match_q != MATCH_FULL) match_d = match_q + MATCH_W'(1);
        end else begin
          match_d = MATCH_W'(1);
          prev_d  = snap_q;
        end
        // Pulses only on entering/leaving the empty state, so a change
        // between non-empty maps just updates the accepted state.
        if ((match_d == MATCH_FULL) && (snap_q != acc_q)) begin
          acc_d = snap_q;
          if ((acc_pop == '0) && (popcount(snap_q) == POP_W'(1))) begin
            valid_d = 1'b1;
            code_d  = lowest_key(snap_q);
          end
          if (snap_q == '0) release_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      dwell_q   <= '0;
      snap_q    <= '0;
      prev_q    <= '0;
      acc_q     <= '0;
      match_q   <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      snap_q    <= snap_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      match_q   <= match_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      release_q <= release_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  localparam int SCAN_LEN = 4 * 4 + 1;
  localparam int LAT      = 2 * SCAN_LEN;

  logic       clk;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_down;
  logic       key_multi;

  logic [15:0] pressed;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    bit         rel;
    logic [3:0] code;
    bit         down;
    bit         multi;
    int         lo;
    int         hi;
  } exp_t;

  exp_t exp_q[$];

  keypad_scanner #(
    .SCAN_TICKS     (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release),
    .key_down    (key_down),
    .key_multi   (key_multi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r * 4 + c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
        total++;
        bad++;
        $display("FAIL event_timeout: no event by cycle %0d (expected rel=%0d code=%0d)",
                 exp_q[0].hi, exp_q[0].rel, exp_q[0].code);
        void'(exp_q.pop_front());
      end
      if (key_valid || key_release) begin
        total++;
        if (key_valid && key_release) begin
          bad++;
          $display("FAIL pulse_overlap: valid=%0b release=%0b required not both at cycle %0d",
                   key_valid, key_release, cyc);
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: valid=%0b release=%0b code=%0d at cycle %0d, none expected",
                   key_valid, key_release, key_code, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (key_release !== e.rel || key_code !== e.code || key_down !== e.down ||
              key_multi !== e.multi || cyc < e.lo || cyc > e.hi) begin
            bad++;
            $display("FAIL event: got rel=%0b code=%0d down=%0b multi=%0b cyc=%0d, expected rel=%0b code=%0d down=%0b multi=%0b cyc=%0d..%0d",
                     key_release, key_code, key_down, key_multi, cyc,
                     e.rel, e.code, e.down, e.multi, e.lo, e.hi);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input bit rel, input logic [3:0] code, input int lo, input int hi);
    exp_t e;
    e.rel   = rel;
    e.code  = code;
    e.down  = !rel;
    e.multi = 1'b0;
    e.lo    = lo;
    e.hi    = hi;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge of the first column-0 cycle of a new scan.
  task automatic wait_scan_start(output int t);
    logic [3:0] prev;
    bit         hit;
    prev = col_n;
    hit  = 1'b0;
    t    = cyc;
    for (int i = 0; i < 3 * SCAN_LEN && !hit; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col_n == 4'b1110) begin
        hit = 1'b1;
        t   = cyc;
      end
      prev = col_n;
    end
    if (!hit) begin
      $display("FAIL scan_align: col_n never wrapped to 1110");
      $fatal(1, "scan alignment lost");
    end
  endtask

  initial begin
    int         t;
    logic [3:0] e;

    reset   = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_col_n", 16'(col_n), 16'h000e);
    check("rst_key_code", 16'(key_code), 16'h0);
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_release", 16'(key_release), 16'h0);
    check("rst_down", 16'(key_down), 16'h0);
    check("rst_multi", 16'(key_multi), 16'h0);

    // Idle scan pattern: four columns of 4 cycles, EVAL, then column 0 again.
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i != 16) begin
        if (i == 17) e = 4'b1110;
        else         e = ~(4'b0001 << (i / 4));
        check("idle_col_n", 16'(col_n), 16'(e));
      end
      @(negedge clk);
    end
    repeat (10 * SCAN_LEN) @(negedge clk);
    check("idle_down", 16'(key_down), 16'h0);
    check("idle_multi", 16'(key_multi), 16'h0);

    // Key 9 (row 2, column 1) press and release.
    wait_scan_start(t);
    pressed[9] = 1'b1;
    expect_event(1'b0, 4'd9, t + LAT, t + LAT);
    repeat (LAT + 2) @(negedge clk);
    check("k9_down", 16'(key_down), 16'h1);
    check("k9_code", 16'(key_code), 16'd9);
    wait_scan_start(t);
    pressed = '0;
    expect_event(1'b1, 4'd9, t + LAT, t + LAT);
    repeat (LAT + 2) @(negedge clk);
    check("k9_rel_code", 16'(key_code), 16'd9);
    check("k9_rel_down", 16'(key_down), 16'h0);

    // Bouncing key 9 for five scans, then steady.
    wait_scan_start(t);
    for (int k = 0; k < 5 * SCAN_LEN; k++) begin
      pressed[9] = (((k + 1) / 3) % 2 == 0);
      @(negedge clk);
    end
    pressed[9] = 1'b1;
    t = cyc;
    expect_event(1'b0, 4'd9, t, t + LAT);
    repeat (LAT + 4) @(negedge clk);
    check("bounce_down", 16'(key_down), 16'h1);
    wait_scan_start(t);
    pressed = '0;
    expect_event(1'b1, 4'd9, t + LAT, t + LAT);
    repeat (LAT + 2) @(negedge clk);

    // Keys 0 and 15 together, then drop 15, then release all.
    wait_scan_start(t);
    pressed[0]  = 1'b1;
    pressed[15] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    check("multi_before", 16'(key_multi), 16'h0);
    @(negedge clk);
    check("multi_level", 16'(key_multi), 16'h1);
    check("multi_down", 16'(key_down), 16'h0);
    wait_scan_start(t);
    pressed[15] = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check("single_down", 16'(key_down), 16'h1);
    check("single_multi", 16'(key_multi), 16'h0);
    check("single_code", 16'(key_code), 16'd9);
    wait_scan_start(t);
    pressed = '0;
    expect_event(1'b1, 4'd9, t + LAT, t + LAT);
    repeat (LAT + 2) @(negedge clk);

    // Key 5 held across a mid-scan reset.
    wait_scan_start(t);
    pressed[5] = 1'b1;
    expect_event(1'b0, 4'd5, t + LAT, t + LAT);
    repeat (LAT + 7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_col_n", 16'(col_n), 16'h000e);
    check("midrst_code", 16'(key_code), 16'h0);
    check("midrst_down", 16'(key_down), 16'h0);
    check("midrst_multi", 16'(key_multi), 16'h0);
    check("midrst_valid", 16'(key_valid), 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t = cyc;
    expect_event(1'b0, 4'd5, t + LAT, t + LAT);
    repeat (LAT + 2) @(negedge clk);
    check("post_rst_code", 16'(key_code), 16'd5);
    check("post_rst_down", 16'(key_down), 16'h1);

    for (int i = 0; i < 4 * SCAN_LEN && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
